seleccion_frecuencia_rep: RTL and testbench
===========================================

SELECCION_FRECUENCIA_REP -- requirements
Module: seleccion_frecuencia_rep

Interface
REQ-001 The block SHALL have parameter W, default 6, the width of f.
REQ-002 The block SHALL have parameter F_MIN, default 0, the lowest selectable value.
REQ-003 The block SHALL have parameter F_MAX, default 63, the highest selectable value; F_MAX SHALL be at most 99 and at most 2^W-1.
REQ-004 The block SHALL have parameter F_INIT, default 0, the value of f after reset, with F_MIN <= F_INIT <= F_MAX.
REQ-005 The block SHALL have parameter STEP, default 1, the increment per step, with STEP >= 1.
REQ-006 The block SHALL have parameter DB_CYC, default 4, the number of stable cycles required to accept a button.
REQ-007 The block SHALL have parameter REP_DLY, default 16, the number of hold cycles after the first step before auto-repeat starts.
REQ-008 The block SHALL have parameter REP_PER, default 4, the number of cycles between auto-repeat steps.
REQ-009 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-010 rst  input  1  reset; asynchronous, active-low.
REQ-011 ENf  input  1  enable; when high, button steps are accepted.
REQ-012 botones  input  2  bit1 = up, bit0 = down; buttons are synchronous to clk and are raw, i.e. they may bounce.
REQ-013 f  output  W  the selected value, registered.
REQ-014 f_deco  output  8  packed BCD of f, tens in [7:4] and units in [3:0], registered.
REQ-015 lim  output  1  high while f equals F_MIN or F_MAX.
REQ-016 paso  output  1  one-cycle pulse on the cycle f changes.

Function
REQ-017 The button code SHALL be sampled each cycle as one of: none (00), up (10), down (01) or both (11).
REQ-018 The FSM SHALL have states IDLE, DEB, STEP1, HOLD, REP and BLOCK.
REQ-019 IDLE SHALL go to DEB on a code of up or down, and SHALL load the debounce counter with 1.
REQ-020 DEB SHALL count while the code is unchanged.
- If the code changes: return to IDLE.
- When the count reaches DB_CYC: go to STEP1.
REQ-021 STEP1 SHALL apply exactly one step on that cycle, then go to HOLD with the hold counter cleared.
REQ-022 HOLD SHALL apply a step and go to REP if the code is still held after REP_DLY cycles.
REQ-023 HOLD SHALL return to IDLE if the code changes.
REQ-024 REP SHALL apply one step every REP_PER cycles while the code is held, and SHALL return to IDLE when the code changes.
REQ-025 A code of both from any state SHALL go to BLOCK with no step; BLOCK SHALL stay until the code is none, then go to IDLE.
REQ-026 When ENf is low, the FSM SHALL be forced to IDLE and f, f_deco and lim SHALL hold their values.
REQ-027 When ENf is low, paso SHALL be 0.
REQ-028 Up step: f_next = f + STEP if f + STEP <= F_MAX; the comparison SHALL be computed at width W+1 so no overflow occurs.
REQ-029 Down step: f_next = f - STEP if f - STEP >= F_MIN; the comparison SHALL be computed signed or at width W+1.
REQ-030 Out-of-range behaviour SHALL follow REQ-040.
REQ-031 paso SHALL be asserted only when f_next differs from f.
REQ-032 A step SHALL update f on the same edge on which the step is applied.
REQ-033 f_deco SHALL equal the BCD of f one cycle later, which is 1 cycle of latency.
REQ-034 lim SHALL be combinational from the registered f.
REQ-035 The latency from a clean press edge to the f update SHALL be DB_CYC+1 cycles.

Reset
REQ-036 While rst is low, the block SHALL hold f = F_INIT, f_deco = BCD(F_INIT), paso = 0, the FSM in IDLE and all counters at 0.
REQ-037 lim SHALL follow F_INIT.
REQ-038 Reset mid-press SHALL abandon the step; after release of reset, a held button SHALL restart from DEB.

Configuration
REQ-039 The macro SELFREQ_WRAP_EN SHALL select the behaviour when a step would leave the range.
REQ-040 Out-of-range behaviour, with and without the macro:
- With SELFREQ_WRAP_EN defined: an up step past F_MAX SHALL load F_MIN, a down step below F_MIN SHALL load F_MAX, and paso SHALL pulse.
- Without SELFREQ_WRAP_EN: f SHALL saturate at the limit and paso SHALL stay 0.

Verification
REQ-041 The bench SHALL cover these directed scenarios, all with default parameters:
- Reset low for 10 cycles, then released -> f=0, f_deco=8'h00, lim=1, paso=0.
- Up held 5 cycles, then released -> f=1 at cycle 5, paso pulses once, f_deco=8'h01 one cycle later.
- Up bouncing 10/00 every 2 cycles for 20 cycles -> f unchanged, paso never asserted.
- Up held 40 cycles from f=0 -> steps at cycles 5, 22, 26, 30, 34, 38, giving f=6.
- Both buttons held 50 cycles, then down -> no step during 11; a single down step occurs after the release to 00 plus DB_CYC+1 cycles.
- f=63 with up held: with SELFREQ_WRAP_EN, f goes to 0 and f_deco=8'h00; without it, f stays 63, lim=1 and paso=0; ENf=0 during a press freezes f.

Source files
------------

// File: rtl/seleccion_frecuencia_rep.sv
// seleccion_frecuencia_rep
// Up/down value selector driven by two raw push buttons. A press is
// debounced, produces one step, and if the button stays held the value
// auto-repeats after an initial delay. Pressing both buttons blocks any
// stepping until both are released.
//
// Optional feature: define SELFREQ_WRAP_EN to make steps past the range
// wrap to the opposite limit; by default the value saturates at the limit.
//
// Ports:
//   clk      single clock, rising edge
//   rst      asynchronous active-low reset
//   ENf      enable; low forces the FSM idle and freezes the value
//   botones  [1] = up, [0] = down, raw (may bounce)
//   f        selected value, registered
//   f_deco   packed BCD of f (tens [7:4], units [3:0]), one cycle behind f
//   lim      high while f sits on F_MIN or F_MAX
//   paso     one-cycle pulse in the cycle f takes a new value
module seleccion_frecuencia_rep #(
    parameter int W       = 6,
    parameter int F_MIN   = 0,
    parameter int F_MAX   = 63,
    parameter int F_INIT  = 0,
    parameter int STEP    = 1,
    parameter int DB_CYC  = 4,
    parameter int REP_DLY = 16,
    parameter int REP_PER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ENf,
    input  logic [1:0]   botones,
    output logic [W-1:0] f,
    output logic [7:0]   f_deco,
    output logic         lim,
    output logic         paso
);

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_UP   = 2'b10;
    localparam logic [1:0] C_DOWN = 2'b01;
    localparam logic [1:0] C_BOTH = 2'b11;

    localparam int CMAX12 = (DB_CYC > REP_DLY) ? DB_CYC : REP_DLY;
    localparam int CMAX   = (CMAX12 > REP_PER) ? CMAX12 : REP_PER;
    // One spare bit so cnt + 1 never wraps before it is compared.
    localparam int CW     = $clog2(CMAX + 2) + 1;

    localparam logic [W-1:0] F_MIN_W  = W'(F_MIN);
    localparam logic [W-1:0] F_MAX_W  = W'(F_MAX);
    localparam logic [W-1:0] F_INIT_W = W'(F_INIT);

    typedef enum logic [2:0] {
        IDLE,
        DEB,
        STEP1,
        HOLD,
        REP,
        BLOCK
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [1:0]     code_q, code_next;
    logic           do_step;
    logic [W-1:0]   f_stepped;
    logic           paso_q;
    logic [W:0]     up_sum;
    logic [W:0]     dn_diff;
    logic           up_ok;
    logic           dn_ok;

    function automatic logic [7:0] to_bcd(input logic [W-1:0] v);
        int unsigned n;
        n = 32'(v);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // State, shared counter, latched button code and the output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= C_NONE;
            f      <= F_INIT_W;
            f_deco <= to_bcd(F_INIT_W);
            paso_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            code_q <= code_next;
            f      <= f_stepped;
            f_deco <= to_bcd(f);
            paso_q <= (f_stepped != f);
        end
    end

    // Next-state logic. The single counter is reused as debounce count,
    // hold-delay count and repeat-period count; every transition into a
    // new phase reloads it. Both-buttons and disable override all states.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code_q;
        do_step    = 1'b0;
        if (!ENf) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (botones == C_BOTH) begin
            state_next = BLOCK;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (botones == C_UP || botones == C_DOWN) begin
                        state_next = DEB;
                        cnt_next   = CW'(1);
                        code_next  = botones;
                    end
                end
                DEB: begin
                    if (botones != code_q) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt + CW'(1) >= CW'(DB_CYC)) begin
                        state_next = STEP1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                // The press is already accepted, so this step happens even
                // if the button is released on this very cycle.
                STEP1: begin
                    do_step    = 1'b1;
                    state_next = HOLD;
                    cnt_next   = '0;
                end
                HOLD: begin
                    if (botones != code_q) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == CW'(REP_DLY)) begin
                        do_step    = 1'b1;
                        state_next = REP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                REP: begin
                    if (botones != code_q) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == CW'(REP_PER - 1)) begin
                        do_step  = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                BLOCK: begin
                    if (botones == C_NONE) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Range checks one bit wider than f. A down step below zero borrows
    // into bit W, which marks it as out of range.
    always_comb begin
        up_sum  = {1'b0, f} + (W+1)'(STEP);
        dn_diff = {1'b0, f} - (W+1)'(STEP);
        up_ok   = (up_sum <= (W+1)'(F_MAX));
        dn_ok   = !dn_diff[W] && (dn_diff[W-1:0] >= F_MIN_W);
    end

    // Value update for an accepted step, including the out-of-range policy.
    always_comb begin
        f_stepped = f;
        if (do_step) begin
            if (code_q == C_UP) begin
                if (up_ok) begin
                    f_stepped = up_sum[W-1:0];
                end else begin
`ifdef SELFREQ_WRAP_EN
                    f_stepped = F_MIN_W;
`else
                    f_stepped = f;
`endif
                end
            end else begin
                if (dn_ok) begin
                    f_stepped = dn_diff[W-1:0];
                end else begin
`ifdef SELFREQ_WRAP_EN
                    f_stepped = F_MAX_W;
`else
                    f_stepped = f;
`endif
                end
            end
        end
    end

    assign lim  = (f == F_MIN_W) || (f == F_MAX_W);
    assign paso = paso_q & ENf;

endmodule

// File: tb/tb_seleccion_frecuencia_rep.sv
// Testbench for seleccion_frecuencia_rep (default parameters). A reference
// model predicts every step from how long the same button code has been
// held; predicted steps go to a queue that a monitor drains on paso.
module tb_seleccion_frecuencia_rep;

    localparam int W       = 6;
    localparam int F_MIN   = 0;
    localparam int F_MAX   = 63;
    localparam int F_INIT  = 0;
    localparam int STEP    = 1;
    localparam int DB_CYC  = 4;
    localparam int REP_DLY = 16;
    localparam int REP_PER = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ENf = 1'b0;
    logic [1:0]   botones = 2'b00;
    logic [W-1:0] f;
    logic [7:0]   f_deco;
    logic         lim;
    logic         paso;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int         cyc = 0;
    int         mf = F_INIT;
    logic [7:0] mdeco;
    int         run = 0;
    bit         blocked = 0;
    logic [1:0] cur = 2'b00;

    seleccion_frecuencia_rep #(
        .W(W), .F_MIN(F_MIN), .F_MAX(F_MAX), .F_INIT(F_INIT), .STEP(STEP),
        .DB_CYC(DB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ENf(ENf),
        .botones(botones),
        .f(f),
        .f_deco(f_deco),
        .lim(lim),
        .paso(paso)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] code, input logic en, input int n);
        botones = code;
        ENf     = en;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference model: a press counts edges with an unchanged code. The
    // edge numbered DB_CYC+1 after the first sampled press steps once;
    // then, still held, a step lands REP_DLY+1 edges later and every
    // REP_PER edges after that.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mf      = F_INIT;
            mdeco   = bcd(F_INIT);
            run     = 0;
            blocked = 0;
        end else begin
            bit do_step;
            int nf;
            int t;
            cyc++;
            do_step = 0;
            mdeco   = bcd(mf);
            if (!ENf) begin
                run = 0;
                blocked = 0;
            end else if (botones == 2'b11) begin
                blocked = 1;
                run = 0;
            end else if (blocked) begin
                if (botones == 2'b00) blocked = 0;
            end else if (run == 0) begin
                if (botones != 2'b00) begin
                    run = 1;
                    cur = botones;
                end
            end else if (run == DB_CYC) begin
                do_step = 1;
                run++;
            end else if (botones != cur) begin
                run = 0;
            end else begin
                if (run > DB_CYC) begin
                    t = run - (DB_CYC + 1 + REP_DLY);
                    if (t >= 0 && (t % REP_PER) == 0) do_step = 1;
                end
                run++;
            end
            if (do_step) begin
                nf = mf;
                if (cur == 2'b10) begin
                    if (mf + STEP <= F_MAX) nf = mf + STEP;
`ifdef SELFREQ_WRAP_EN
                    else nf = F_MIN;
`endif
                end else begin
                    if (mf - STEP >= F_MIN) nf = mf - STEP;
`ifdef SELFREQ_WRAP_EN
                    else nf = F_MAX;
`endif
                end
                if (nf != mf) exp_q.push_back('{cyc, 8'(nf)});
                mf = nf;
            end
        end
    end

    // Monitor: compares outputs against the model every cycle and drains
    // the step queue whenever paso is seen.
    always @(negedge clk) begin
        exp_t e;
        check_output("f", 32'(f), 32'(mf));
        check_output("f_deco", 32'(f_deco), 32'(mdeco));
        check_output("lim", 32'(lim), 32'((mf == F_MIN) || (mf == F_MAX)));
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check_output("missed_step_cycle", 32'(0), 32'(e.cyc));
        end
        if (paso) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_paso", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check_output("step_cycle", 32'(cyc), 32'(e.cyc));
                check_output("step_value", 32'(f), 32'(e.val));
            end
        end
    end

    initial begin
        int r;
        logic [1:0] code;
        logic en;
        $display("[TB] start");
        #1;
        pulse_reset(10);
        ENf = 1'b1;
        check_output("reset_f", 32'(f), 32'(0));
        check_output("reset_f_deco", 32'(f_deco), 32'h00);
        check_output("reset_lim", 32'(lim), 32'(1));
        check_output("reset_paso", 32'(paso), 32'(0));

        // Single press
        apply_stimulus(2'b10, 1'b1, 5);
        apply_stimulus(2'b00, 1'b1, 3);
        check_output("single_press_f", 32'(f), 32'(1));
        check_output("single_press_deco", 32'(f_deco), 32'h01);

        // Bouncing button never gets accepted
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'b10, 1'b1, 2);
            apply_stimulus(2'b00, 1'b1, 2);
        end
        check_output("bounce_f", 32'(f), 32'(1));

        // Long hold from zero
        pulse_reset(3);
        apply_stimulus(2'b10, 1'b1, 40);
        apply_stimulus(2'b00, 1'b1, 3);
        check_output("hold40_f", 32'(f), 32'(6));

        // Both buttons block, then a clean down press
        apply_stimulus(2'b11, 1'b1, 50);
        check_output("both_f", 32'(f), 32'(6));
        apply_stimulus(2'b00, 1'b1, 3);
        apply_stimulus(2'b01, 1'b1, 6);
        apply_stimulus(2'b00, 1'b1, 2);
        check_output("after_both_down_f", 32'(f), 32'(5));

        // Run into the top limit
        apply_stimulus(2'b10, 1'b1, 300);
        apply_stimulus(2'b00, 1'b1, 2);
`ifndef SELFREQ_WRAP_EN
        check_output("sat_f", 32'(f), 32'(63));
        check_output("sat_lim", 32'(lim), 32'(1));
`endif

        // Disabled press freezes the value
        apply_stimulus(2'b01, 1'b0, 30);
        check_output("disabled_f", 32'(f), 32'(mf));
        check_output("disabled_paso", 32'(paso), 32'(0));
        apply_stimulus(2'b00, 1'b1, 2);

        // Reset in the middle of a press, then keep holding
        apply_stimulus(2'b01, 1'b1, 3);
        pulse_reset(2);
        apply_stimulus(2'b01, 1'b1, 8);
        apply_stimulus(2'b00, 1'b1, 2);

        // Randomized segments
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 2) code = 2'b00;
            else if (r < 5) code = 2'b10;
            else if (r < 8) code = 2'b01;
            else if (r == 8) code = 2'b11;
            else code = 2'(s);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) pulse_reset($urandom_range(1, 3));
            apply_stimulus(code, en, $urandom_range(1, 45));
        end

        apply_stimulus(2'b00, 1'b1, 5);
        check_output("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
